// File: rtl/counter_share_ctrl_if.sv
// Bundle between the two requesting control FSMs, the shared counter datapath
// and the counter_share_ctrl scheduler.
// master: requester/datapath side (drives req, len0/len1, cnt_q); slave: scheduler side.
//   req[1:0]    level request per requester, held until done or abort
//   len0, len1  interval length per requester, sampled at grant
//   cnt_q       current shared counter value
//   cnt_clr     clear command to the counter (takes effect at next edge)
//   cnt_en      count-enable command to the counter (takes effect at next edge)
//   gnt[1:0]    one-hot grant, held for the whole operation
//   done[1:0]   one-cycle completion pulse to the granted requester
//   busy        scheduler not idle
interface counter_share_ctrl_if #(
  parameter int WIDTH = 4
);
  logic [1:0]       req;
  logic [WIDTH-1:0] len0;
  logic [WIDTH-1:0] len1;
  logic [WIDTH-1:0] cnt_q;
  logic             cnt_clr;
  logic             cnt_en;
  logic [1:0]       gnt;
  logic [1:0]       done;
  logic             busy;

  modport master (
    output req, len0, len1, cnt_q,
    input  cnt_clr, cnt_en, gnt, done, busy
  );

  modport slave (
    input  req, len0, len1, cnt_q,
    output cnt_clr, cnt_en, gnt, done, busy
  );
endinterface

// File: rtl/counter_share_ctrl.sv
// Purpose: round-robin scheduler sharing one up-counter between two interval requesters.
// Latency: grant 1 cycle after request; done pulses len+3 cycles after the granting edge.
// Backpressure: requests are level-held; dropping req[sel] in CLEAR/COUNT aborts the operation.
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    counter_share_ctrl_if.slave (req/len0/len1/cnt_q in; cnt_clr/cnt_en/gnt/done/busy out)
module counter_share_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  counter_share_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_COUNT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_sel;
  logic             r_ptr;
  logic [WIDTH-1:0] r_target;

  state_t           w_next_state;
  logic             w_pick_vld;
  logic             w_pick;
  logic             w_abort;
  logic             w_at_target;
  logic [1:0]       w_gnt;
  logic [1:0]       w_done;
  logic             w_cnt_clr;
  logic             w_cnt_en;
  logic             w_busy;

  assign w_at_target = (bus.cnt_q == r_target);

  // State register plus the per-operation context (winner, target, rr pointer).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_sel    <= 1'b0;
      r_ptr    <= 1'b0;
      r_target <= '0;
    end else begin
      r_state <= w_next_state;
      // target is latched only at selection, so later len changes are ignored
      if (w_pick_vld) begin
        r_sel    <= w_pick;
        r_target <= w_pick ? bus.len1 : bus.len0;
      end
      // Both completion and abort hand priority to the other requester
      if (w_abort || (r_state == S_DONE)) begin
        r_ptr <= ~r_sel;
      end
    end
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    w_pick_vld   = 1'b0;
    w_pick       = r_ptr;
    w_abort      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.req[r_ptr]) begin
          w_pick_vld = 1'b1;
          w_pick     = r_ptr;
        end else if (bus.req[~r_ptr]) begin
          w_pick_vld = 1'b1;
          w_pick     = ~r_ptr;
        end
        if (w_pick_vld) begin
          w_next_state = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (!bus.req[r_sel]) begin
          w_abort      = 1'b1;
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_COUNT;
        end
      end
      S_COUNT: begin
        // Abort wins over reaching the target in the same cycle
        if (!bus.req[r_sel]) begin
          w_abort      = 1'b1;
          w_next_state = S_IDLE;
        end else if (w_at_target) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Output decode from registered state plus cnt_q/req
  always_comb begin
    w_gnt     = 2'b00;
    w_done    = 2'b00;
    w_cnt_clr = 1'b0;
    w_cnt_en  = 1'b0;
    w_busy    = (r_state != S_IDLE);
    if (r_state != S_IDLE) begin
      w_gnt = r_sel ? 2'b10 : 2'b01;
    end
    case (r_state)
      S_CLEAR: w_cnt_clr = 1'b1;
      // Stop at equality so the counter never wraps; gate on req for same-cycle abort
      S_COUNT: w_cnt_en  = bus.req[r_sel] && !w_at_target;
      S_DONE:  w_done    = r_sel ? 2'b10 : 2'b01;
      default: ;
    endcase
  end

  assign bus.gnt     = w_gnt;
  assign bus.done    = w_done;
  assign bus.cnt_clr = w_cnt_clr;
  assign bus.cnt_en  = w_cnt_en;
  assign bus.busy    = w_busy;

endmodule

// File: tb/tb_counter_share_ctrl.sv
// Directed bench for counter_share_ctrl with a behavioural model of the shared counter.
module tb_counter_share_ctrl;

  localparam int WIDTH = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;

  counter_share_ctrl_if #(.WIDTH(WIDTH)) bus ();

  counter_share_ctrl #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Shared counter datapath: clear has priority over enable
  logic [WIDTH-1:0] cnt_model = '0;
  always_ff @(posedge clock) begin
    if (bus.cnt_clr)     cnt_model <= '0;
    else if (bus.cnt_en) cnt_model <= cnt_model + 1'b1;
  end
  assign bus.cnt_q = cnt_model;

  int n_checks = 0;
  int n_pass   = 0;

  // Observed output vector: {gnt[1:0], done[1:0], busy, cnt_clr, cnt_en}
  logic [6:0] obs;
  assign obs = {bus.gnt, bus.done, bus.busy, bus.cnt_clr, bus.cnt_en};

  // Expected outputs in cycle k (1 = first cycle after the granting edge)
  // for requester r with length t and req held throughout.
  function automatic logic [6:0] exp_vec(input int k, input int t, input logic r);
    logic [1:0] g;
    g = r ? 2'b10 : 2'b01;
    if (k == 1)                 return {g, 2'b00, 3'b110};
    if (k >= 2 && k <= t + 1)   return {g, 2'b00, 3'b101};
    if (k == t + 2)             return {g, 2'b00, 3'b100};
    if (k == t + 3)             return {g, g,     3'b100};
    return 7'b0;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    bus.req  = 2'b00;
    bus.len0 = '0;
    bus.len1 = '0;
    reset    = 1'b0;
    #3;
    n_checks++;
    if (obs !== 7'b0) $display("FAIL reset_low outputs=%b expected=%b", obs, 7'b0);
    else n_pass++;
    step();
    reset = 1'b1;
    step();
    n_checks++;
    if (obs !== 7'b0) $display("FAIL reset_release outputs=%b expected=%b", obs, 7'b0);
    else n_pass++;
  endtask

  task automatic test_single();
    bus.len0 = 4'd5;
    bus.req  = 2'b01;
    for (int k = 1; k <= 9; k++) begin
      step();
      n_checks++;
      if (obs !== exp_vec(k, 5, 1'b0))
        $display("FAIL single k=%0d outputs=%b expected=%b", k, obs, exp_vec(k, 5, 1'b0));
      else n_pass++;
      if (k == 8) begin
        n_checks++;
        if (bus.cnt_q !== 4'd5) $display("FAIL single_cnt_q cnt_q=%0d expected=5", bus.cnt_q);
        else n_pass++;
        bus.req = 2'b00;
      end
    end
  endtask

  // ptr is 1 on entry; an asynchronous reset mid-count must zero everything and ptr.
  task automatic test_reset_mid_count();
    bus.len1 = 4'd9;
    bus.req  = 2'b10;
    for (int k = 1; k <= 5; k++) begin
      step();
      n_checks++;
      if (obs !== exp_vec(k, 9, 1'b1))
        $display("FAIL rst_mid_pre k=%0d outputs=%b expected=%b", k, obs, exp_vec(k, 9, 1'b1));
      else n_pass++;
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (obs !== 7'b0) $display("FAIL rst_mid_immediate outputs=%b expected=%b", obs, 7'b0);
    else n_pass++;
    step();
    reset    = 1'b1;
    bus.len0 = 4'd3;
    bus.req  = 2'b11;
    #1;
    n_checks++;
    if (obs !== 7'b0) $display("FAIL rst_mid_release outputs=%b expected=%b", obs, 7'b0);
    else n_pass++;
    step();
    n_checks++;
    if (obs !== exp_vec(1, 3, 1'b0))
      $display("FAIL rst_mid_ptr outputs=%b expected=%b", obs, exp_vec(1, 3, 1'b0));
    else n_pass++;
    // Abort from CLEAR: ptr moves to requester 1
    bus.req = 2'b00;
    step();
    n_checks++;
    if (obs !== 7'b0) $display("FAIL rst_mid_abort outputs=%b expected=%b", obs, 7'b0);
    else n_pass++;
  endtask

  task automatic test_zero_len();
    bus.len1 = 4'd0;
    bus.req  = 2'b10;
    for (int k = 1; k <= 4; k++) begin
      step();
      n_checks++;
      if (obs !== exp_vec(k, 0, 1'b1))
        $display("FAIL zero_len k=%0d outputs=%b expected=%b", k, obs, exp_vec(k, 0, 1'b1));
      else n_pass++;
      if (k == 3) begin
        n_checks++;
        if (bus.cnt_q !== 4'd0) $display("FAIL zero_len_cnt_q cnt_q=%0d expected=0", bus.cnt_q);
        else n_pass++;
        bus.req = 2'b00;
      end
    end
  endtask

  task automatic test_contention();
    logic       who [4];
    int         len [4];
    who = '{1'b0, 1'b1, 1'b0, 1'b1};
    len = '{3, 2, 3, 2};
    bus.len0 = 4'd3;
    bus.len1 = 4'd2;
    bus.req  = 2'b11;
    for (int op = 0; op < 4; op++) begin
      for (int k = 1; k <= len[op] + 4; k++) begin
        step();
        n_checks++;
        if (obs !== exp_vec(k, len[op], who[op]))
          $display("FAIL contention op=%0d k=%0d outputs=%b expected=%b",
                   op, k, obs, exp_vec(k, len[op], who[op]));
        else n_pass++;
        if (k == len[op] + 3) begin
          n_checks++;
          if (int'(bus.cnt_q) != len[op])
            $display("FAIL contention_cnt_q op=%0d cnt_q=%0d expected=%0d", op, bus.cnt_q, len[op]);
          else n_pass++;
          if (op == 3) bus.req = 2'b00;
        end
      end
    end
  endtask

  task automatic test_abort();
    bus.len0 = 4'd15;
    bus.req  = 2'b01;
    for (int k = 1; k <= 5; k++) begin
      step();
      n_checks++;
      if (obs !== exp_vec(k, 15, 1'b0))
        $display("FAIL abort_pre k=%0d outputs=%b expected=%b", k, obs, exp_vec(k, 15, 1'b0));
      else n_pass++;
    end
    step();
    bus.req = 2'b00;
    #1;
    n_checks++;
    if (obs !== 7'b0100100) $display("FAIL abort_cycle outputs=%b expected=%b", obs, 7'b0100100);
    else n_pass++;
    step();
    n_checks++;
    if (obs !== 7'b0) $display("FAIL abort_idle outputs=%b expected=%b", obs, 7'b0);
    else n_pass++;
    n_checks++;
    if (bus.cnt_q !== 4'd4) $display("FAIL abort_partial cnt_q=%0d expected=4", bus.cnt_q);
    else n_pass++;
  endtask

  // ptr is 1 after the abort, so requester 1 wins contention with max length
  task automatic test_max_len();
    bus.len1 = 4'd15;
    bus.req  = 2'b11;
    for (int k = 1; k <= 19; k++) begin
      step();
      n_checks++;
      if (obs !== exp_vec(k, 15, 1'b1))
        $display("FAIL max_len k=%0d outputs=%b expected=%b", k, obs, exp_vec(k, 15, 1'b1));
      else n_pass++;
      if (k == 3) bus.len1 = 4'd2;
      if (k == 18) begin
        n_checks++;
        if (bus.cnt_q !== 4'd15) $display("FAIL max_len_cnt_q cnt_q=%0d expected=15", bus.cnt_q);
        else n_pass++;
        bus.req = 2'b00;
      end
    end
    step();
    n_checks++;
    if (bus.cnt_q !== 4'd15) $display("FAIL max_len_no_wrap cnt_q=%0d expected=15", bus.cnt_q);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset_mid_count();
    test_zero_len();
    test_contention();
    test_abort();
    test_max_len();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
